// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU/cache handshake and strobe bundle for the cache controller
interface cache_controller_if;
  logic memRead;
  logic memWrite;
  logic hit;
  logic writeMem;
  logic writeCache;
  logic MemToCache;
  logic stall;
  modport master (output memRead, memWrite, hit, input writeMem, writeCache, MemToCache, stall);
  modport slave (input memRead, memWrite, hit, output writeMem, writeCache, MemToCache, stall);
endinterface

// File: rtl/cache_controller.sv
// cache_controller: write-through, no-write-allocate cache FSM with latency wait and saturating hit/miss statistics
module cache_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  cache_controller_if.slave bus,
  output logic [CNT_W-1:0] hitCount,
  output logic [CNT_W-1:0] missCount
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MEM_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_FILL, WR_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic hit_inc, miss_inc, write_mem, write_cache, mem_to_cache, stall;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hit_inc = 1'b0;
    miss_inc = 1'b0;
    write_mem = 1'b0;
    write_cache = 1'b0;
    mem_to_cache = 1'b0;
    stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.memWrite || bus.memRead) begin
          hit_inc = bus.hit;
          miss_inc = !bus.hit;
        end
        if (bus.memWrite) begin
          stall = 1'b1;
          cnt_d = LOAD;
          state_d = WR_WAIT;
        end else if (bus.memRead && !bus.hit) begin
          stall = 1'b1;
          cnt_d = LOAD;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        state_d = (cnt_q == '0) ? RD_FILL : RD_WAIT;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      RD_FILL: begin
        mem_to_cache = 1'b1;
        state_d = IDLE;
      end
      WR_WAIT: begin
        stall = (cnt_q != '0);
        write_mem = (cnt_q == '0);
        write_cache = (cnt_q == '0) && bus.hit;
        state_d = (cnt_q == '0) ? IDLE : WR_WAIT;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    hit_cnt_d = (hit_inc && hit_cnt_q != '1) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = (miss_inc && miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign bus.writeMem = write_mem & ~reset;
  assign bus.writeCache = write_cache & ~reset;
  assign bus.MemToCache = mem_to_cache & ~reset;
  assign bus.stall = stall & ~reset;
  assign hitCount = hit_cnt_q;
  assign missCount = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed and randomized checks against a transaction-age model of the cache controller
module tb_cache_controller;
  localparam int ML = 4;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [15:0] hit_count, miss_count;
  logic [1:0] hit_count_s, miss_count_s;
  cache_controller_if bus ();
  cache_controller_if bus_s ();
  always #5 clk = ~clk;
  cache_controller #(.MEM_LATENCY(ML), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .hitCount(hit_count), .missCount(miss_count)
  );
  cache_controller #(.MEM_LATENCY(ML), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s.slave), .hitCount(hit_count_s), .missCount(miss_count_s)
  );
  assign bus_s.memRead = bus.memRead;
  assign bus_s.memWrite = bus.memWrite;
  assign bus_s.hit = bus.hit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // model: a pending operation is tracked by its kind and the cycles elapsed since acceptance
  bit busy = 0, is_wr = 0;
  int age = 0, m_hits = 0, m_miss = 0;
  always @(negedge clk) begin
    logic e_stall, e_wm, e_wc, e_mtc;
    chk("hitCount", 32'(hit_count), 32'(sat(m_hits, 65535)));
    chk("missCount", 32'(miss_count), 32'(sat(m_miss, 65535)));
    chk("hitCount_sat", 32'(hit_count_s), 32'(sat(m_hits, 3)));
    chk("missCount_sat", 32'(miss_count_s), 32'(sat(m_miss, 3)));
    e_stall = 0; e_wm = 0; e_wc = 0; e_mtc = 0;
    if (reset) begin
      busy = 0; m_hits = 0; m_miss = 0;
    end else if (!busy) begin
      if (bus.memWrite) begin
        e_stall = 1; busy = 1; is_wr = 1; age = 0;
        if (bus.hit) m_hits++; else m_miss++;
      end else if (bus.memRead) begin
        if (bus.hit) m_hits++;
        else begin m_miss++; e_stall = 1; busy = 1; is_wr = 0; age = 0; end
      end
    end else begin
      age++;
      if (is_wr) begin
        if (age < ML) e_stall = 1;
        else begin e_wm = 1; e_wc = bus.hit; busy = 0; end
      end else begin
        if (age <= ML) e_stall = 1;
        else begin e_mtc = 1; busy = 0; end
      end
    end
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("writeMem", 32'(bus.writeMem), 32'(e_wm));
    chk("writeCache", 32'(bus.writeCache), 32'(e_wc));
    chk("MemToCache", 32'(bus.MemToCache), 32'(e_mtc));
    chk("stall_s", 32'(bus_s.stall), 32'(e_stall));
    chk("strobes_s", 32'({bus_s.writeMem, bus_s.writeCache, bus_s.MemToCache}), 32'({e_wm, e_wc, e_mtc}));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic hold;
    reset = 1; bus.memRead = 1; bus.memWrite = 1; bus.hit = 0;
    #1; cyc();
    @(negedge clk);
    chk("reset_outputs", 32'({bus.stall, bus.writeMem, bus.writeCache, bus.MemToCache}), 32'h0);
    chk("reset_counts", 32'({hit_count, miss_count}), 32'h0);
    cyc();
    reset = 0; bus.memWrite = 0; bus.hit = 1;
    @(negedge clk); chk("rd_hit_stall", 32'(bus.stall), 32'h0);
    cyc(); bus.memRead = 0;
    @(negedge clk); chk("rd_hit_count", 32'(hit_count), 32'h1);
    cyc(); bus.memRead = 1; bus.hit = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("rd_miss_stall", 32'({bus.stall, bus.MemToCache}), 32'h2);
      cyc();
    end
    @(negedge clk);
    chk("rd_miss_fill", 32'({bus.stall, bus.MemToCache}), 32'h1);
    chk("rd_miss_count", 32'(miss_count), 32'h1);
    cyc(); bus.memRead = 0;
    @(negedge clk); chk("rd_miss_idle", 32'({bus.stall, bus.MemToCache}), 32'h0);
    cyc(); bus.memWrite = 1; bus.hit = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("wr_hit_stall", 32'({bus.stall, bus.writeMem}), 32'h2);
      cyc();
    end
    @(negedge clk);
    chk("wr_hit_strobes", 32'({bus.stall, bus.writeMem, bus.writeCache}), 32'h3);
    chk("wr_hit_count", 32'(hit_count), 32'h2);
    cyc(); bus.memWrite = 0;
    cyc(); bus.memWrite = 1; bus.memRead = 1; bus.hit = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("wr_miss_stall", 32'({bus.stall, bus.writeMem, bus.MemToCache}), 32'h4);
      cyc();
    end
    @(negedge clk);
    chk("wr_miss_strobes", 32'({bus.stall, bus.writeMem, bus.writeCache, bus.MemToCache}), 32'h4);
    chk("wr_miss_count", 32'(miss_count), 32'h2);
    cyc(); bus.memWrite = 0; bus.memRead = 0;
    cyc(); bus.memRead = 1; bus.hit = 0;
    cyc(); cyc(); cyc(); reset = 1;
    @(negedge clk); chk("reset_mid_outputs", 32'({bus.stall, bus.MemToCache}), 32'h0);
    cyc(); reset = 0; bus.memRead = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("reset_mid_idle", 32'({bus.stall, bus.MemToCache}), 32'h0);
      chk("reset_mid_counts", 32'({hit_count, miss_count}), 32'h0);
      cyc();
    end
    bus.memRead = 1; bus.hit = 1;
    for (int i = 0; i < 5; i++) cyc();
    bus.memRead = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sat_hitCount", 32'(hit_count_s), 32'h3);
      chk("nosat_hitCount", 32'(hit_count), 32'h5);
      cyc();
    end
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk); hold = bus.stall;
      cyc();
      reset = ($urandom_range(0, 149) == 0);
      bus.hit = 1'($urandom_range(0, 1));
      if (!(hold && $urandom_range(0, 9) != 0)) begin
        bus.memRead = ($urandom_range(0, 2) != 0);
        bus.memWrite = ($urandom_range(0, 2) == 0);
      end
    end
    reset = 0; bus.memRead = 0; bus.memWrite = 0;
    for (int i = 0; i < 8; i++) cyc();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter MEM_LATENCY, default 4, main-memory access time in cycles; legal range 1..255.
REQ-002 Parameter CNT_W, default 16, width of the hit and miss statistics counters.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port memRead  input  1  CPU load request, held with a stable address until stall is low at a rising edge.
REQ-006 Port memWrite  input  1  CPU store request, held with stable address and data until stall is low at a rising edge.
REQ-007 Port hit  input  1  combinational tag-match from memory_cache for the current address.
REQ-008 Port writeMem  output  1  drives memory_cache writeMem.
REQ-009 Port writeCache  output  1  drives memory_cache writeCache.
REQ-010 Port MemToCache  output  1  drives memory_cache MemToCache (16-word line fill).
REQ-011 Port stall  output  1  CPU hold; high means the request is not complete this cycle.
REQ-012 Port hitCount  output  CNT_W  accepted requests that hit.
REQ-013 Port missCount  output  CNT_W  accepted requests that missed.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_WAIT, RD_FILL and WR_WAIT, plus a latency down-counter wide enough for MEM_LATENCY-1.
REQ-015 writeMem, writeCache, MemToCache and stall SHALL be combinational functions of state, counter, memRead, memWrite and hit.
REQ-016 IDLE with no request: all control outputs low; state unchanged.
REQ-017 IDLE with memWrite=1: memWrite wins over memRead; stall=1; counter loads MEM_LATENCY-1; next state WR_WAIT; hitCount++ if hit=1, otherwise missCount++.
REQ-018 IDLE with memRead=1, memWrite=0, hit=1: stall=0, no strobes, hitCount++, state unchanged (zero-wait hit).
REQ-019 IDLE with memRead=1, memWrite=0, hit=0: stall=1; counter loads MEM_LATENCY-1; missCount++; next state RD_WAIT.
REQ-020 RD_WAIT: stall=1; if counter=0, next state RD_FILL, otherwise decrement.
REQ-021 RD_FILL: MemToCache=1 and stall=0 for exactly one cycle; the CPU captures memory data through the miss path; next state IDLE.
REQ-022 WR_WAIT, counter not 0: stall=1, decrement, no strobes.
REQ-023 WR_WAIT, counter=0: writeMem=1 and stall=0; writeCache=hit sampled this cycle (write-through, no write-allocate); next state IDLE.
REQ-024 Read-miss occupancy SHALL be MEM_LATENCY+2 cycles with MEM_LATENCY+1 stalled; write occupancy SHALL be MEM_LATENCY+1 cycles with MEM_LATENCY stalled.
REQ-025 writeMem, writeCache and MemToCache SHALL each be high for at most one cycle per request and never together with MemToCache.
REQ-026 A request dropped mid-operation SHALL NOT abort the operation; it completes and counts normally.
REQ-027 A request present in the IDLE cycle following completion is a new request.
REQ-028 hitCount and missCount SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, counter 0, and hitCount=missCount=0, overriding any transition.
REQ-030 While reset=1, writeMem, writeCache, MemToCache and stall SHALL be 0 regardless of the inputs.
REQ-031 Reset in RD_WAIT or WR_WAIT SHALL abandon the operation without issuing any strobe.

Verification
REQ-032 Read hit: memRead=1, hit=1 for 1 cycle -> stall=0, no strobes, hitCount=1.
REQ-033 Read miss, MEM_LATENCY=4: memRead=1, hit=0 -> stall high 5 cycles, then MemToCache=1 with stall=0 in cycle 6; missCount=1; IDLE in cycle 7.
REQ-034 Write hit, MEM_LATENCY=4: memWrite=1, hit=1 -> stall high 4 cycles, cycle 5 writeMem=writeCache=1 with stall=0; hitCount=1.
REQ-035 Write miss and priority: memRead=memWrite=1, hit=0 -> write path taken, cycle 5 writeMem=1, writeCache=0; missCount=1; no MemToCache.
REQ-036 Reset mid-miss: reset asserted in the 3rd RD_WAIT cycle -> next cycle IDLE, counters 0, MemToCache never asserted.
REQ-037 Saturation with CNT_W=2: 5 consecutive read hits -> hitCount=3 and held.
